pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: clk and rst; the polarity and synchronicity are fixed.
REQ-002 Port list (name  direction  width  meaning), clock and reset first:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- Pcsrc  in  2  next-PC select from the branch/jump controller: 00 = sequential, 10 = branch, 11 = jump, 01 = reserved
- Condep  in  1  0 = squash the instruction held in IF/ID (taken branch)
- Btarget  in  32  branch target computed in EX
- Stall  in  1  load-use hazard hold from the ID stage
- Idata  in  32  instruction memory read data
- Irdy  in  1  Idata valid this cycle
- Iaddr  out  32  fetch address, equal to Pc
- dInst  out  32  IF/ID instruction
- dPc4  out  32  IF/ID PC+4
- dValid  out  1  IF/ID holds a real instruction
- Fcnt  out  32  count of instructions delivered to ID

Function
REQ-003 The block SHALL hold a 32-bit Pc register and drive Iaddr = Pc combinationally.
REQ-004 The block SHALL form the jump target combinationally as {dPc4[31:28], dInst[25:0], 2'b00}.
REQ-005 The block SHALL select the next Pc with this priority, highest first:
- (a) Pcsrc=10 -> Btarget
- (b) Pcsrc=11 and Stall=0 -> jump target
- (c) Stall=1 -> hold
- (d) Irdy=0 -> hold
- (e) otherwise -> Pc+4
REQ-006 Pcsrc=01 and Pcsrc=11 with Stall=1 SHALL both be treated as 00.
REQ-007 All PC arithmetic SHALL be 32-bit modulo: Pc=FFFFFFFC with sequential advance yields 00000000.
REQ-008 When Condep=0, the IF/ID register SHALL load dValid=0 on that edge, regardless of Stall and Irdy; dInst and dPc4 are don't-care.
REQ-009 When Condep=1 and Stall=1, the IF/ID register SHALL hold dInst, dPc4 and dValid unchanged.
REQ-010 When Condep=1, Stall=0 and Irdy=1, the IF/ID register SHALL load dInst=Idata, dPc4=Pc+4 and dValid=1.
REQ-011 When Condep=1, Stall=0 and Irdy=0, the IF/ID register SHALL load a bubble: dValid=0, dInst=0, dPc4 held.
REQ-012 A jump (Pcsrc=11 accepted) SHALL NOT squash IF/ID; the instruction fetched in the same cycle enters ID as the delay slot, per REQ-010/011.
REQ-013 Fcnt SHALL increment by 1 on each edge where REQ-010 applies, and wrap from FFFFFFFF to 0.
REQ-014 Latency: Pc SHALL take a redirect target on the edge at which Pcsrc is sampled; the target instruction appears in IF/ID no earlier than the following edge with Irdy=1.
REQ-015 A branch redirect (Pcsrc=10) arriving with Irdy=0 SHALL still load Btarget into Pc, and the stale fetch SHALL never reach IF/ID.
REQ-016 Simultaneous Pcsrc=10 and Condep=0 (the normal taken-branch case) SHALL load Pc=Btarget and squash IF/ID on the same edge.
REQ-017 dInst bit 31..26 = 000010 with dValid=0 SHALL NOT affect Pc; an externally asserted Pcsrc=11 is qualified by Stall only.
REQ-018 All state SHALL update only on the rising edge of clk, except the reset response in REQ-019.

Reset
REQ-019 While rst=1, the block SHALL asynchronously force Pc=00000000, dInst=00000000, dPc4=00000000, dValid=0 and Fcnt=00000000.
REQ-020 On the first rising edge after rst deasserts with Irdy=1, the block SHALL fetch from 00000000 and present dValid=1 and dPc4=00000004.
REQ-021 rst asserted mid-operation (pending stall, redirect or wait) SHALL discard all in-flight state; no redirect survives reset.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Reset then Irdy=1, Pcsrc=00 for 3 cycles -> Iaddr 0, 4, 8, C; Fcnt=3; dPc4=C.
- Pc=100, Pcsrc=10, Btarget=200, Condep=0 -> next Pc=200, dValid=0; next cycle dPc4=204, dValid=1.
- dInst=08000040 (j), dPc4=10000010, Pcsrc=11, Stall=0 -> Pc=10000100; the delay-slot instruction enters ID with dValid=1.
- Stall=1 with Pcsrc=11 for 2 cycles -> Pc and IF/ID unchanged, Fcnt unchanged; Stall drops -> jump taken.
- Irdy=0 for 2 cycles, with Pcsrc=10 and Btarget=300 asserted in cycle 1 -> Pc=300, dValid=0 both cycles; Irdy=1 -> dPc4=304.
- Pc=FFFFFFFC, Irdy=1 -> Pc=00000000; and rst pulsed mid-stall -> all outputs zero immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_fetch_if.sv
// pc_fetch_if -- fetch-stage bundle between the pipeline control / instruction
// memory side (master) and the fetch block (slave).
//
// Handshake: Irdy is a valid-only qualifier on Idata. There is no ready in the
// reverse direction. The fetch block consumes Idata on every rising edge where
// Irdy=1, Stall=0 and Condep=1. Otherwise the word is dropped, and memory
// re-presents the word for whatever Iaddr shows next.
//
// Signals:
//   Pcsrc   [1:0]  next-PC select (00 seq, 10 branch, 11 jump, 01 reserved)
//   Condep         0 squashes the IF/ID register
//   Btarget [31:0] branch target from EX
//   Stall          load-use hold from ID
//   Idata   [31:0] instruction memory read data
//   Irdy           Idata valid this cycle
//   Iaddr   [31:0] fetch address (== Pc)
//   dInst   [31:0] IF/ID instruction
//   dPc4    [31:0] IF/ID PC+4
//   dValid         IF/ID holds a real instruction
//   Fcnt    [31:0] instructions delivered to ID
interface pc_fetch_if;
  logic [1:0]  Pcsrc;
  logic        Condep;
  logic [31:0] Btarget;
  logic        Stall;
  logic [31:0] Idata;
  logic        Irdy;
  logic [31:0] Iaddr;
  logic [31:0] dInst;
  logic [31:0] dPc4;
  logic        dValid;
  logic [31:0] Fcnt;

  modport master (
    output Pcsrc, Condep, Btarget, Stall, Idata, Irdy,
    input  Iaddr, dInst, dPc4, dValid, Fcnt
  );

  modport slave (
    input  Pcsrc, Condep, Btarget, Stall, Idata, Irdy,
    output Iaddr, dInst, dPc4, dValid, Fcnt
  );
endinterface

// File: rtl/pc_fetch.sv
// pc_fetch -- instruction fetch stage. It holds the PC and the IF/ID pipeline
// register, and it counts the instructions delivered to ID.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset; clears the PC, IF/ID and the count
//   bus   pc_fetch_if.slave; the signals are listed in the interface header
//
// Next-PC priority, highest first: branch, unstalled jump, stall hold,
// memory-wait hold, sequential. Pcsrc=01 falls through as sequential. A
// stalled jump also falls through, so it becomes a hold.
module pc_fetch (
  input  logic        clk,
  input  logic        rst,
  pc_fetch_if.slave   bus
);

  localparam logic [1:0] PCSRC_BRANCH = 2'b10;
  localparam logic [1:0] PCSRC_JUMP   = 2'b11;

  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] pc4_q;
  logic        valid_q;
  logic [31:0] cnt_q;

  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] pc_next;
  logic        take_branch;
  logic        take_jump;
  logic        deliver;

  assign pc_plus4    = pc_q + 32'd4;  // modulo 2^32 by width
  // The jump target is built from the jump already sitting in IF/ID.
  assign jump_target = {pc4_q[31:28], inst_q[25:0], 2'b00};

  assign take_branch = (bus.Pcsrc == PCSRC_BRANCH);
  // The jump controller decides by itself that a jump is present. Only Stall
  // qualifies it; the opcode bits of dInst and dValid are not examined.
  assign take_jump   = (bus.Pcsrc == PCSRC_JUMP) && !bus.Stall;

  // A fetched word enters ID only when nothing squashes it or holds it.
  assign deliver     = bus.Condep && !bus.Stall && bus.Irdy;

  always_comb begin
    pc_next = pc_plus4;
    if (take_branch) begin
      pc_next = bus.Btarget;
    end else if (take_jump) begin
      pc_next = jump_target;
    end else if (bus.Stall || !bus.Irdy) begin
      pc_next = pc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= 32'd0;
      inst_q  <= 32'd0;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      pc_q <= pc_next;
      if (!bus.Condep) begin
        // Squash. dInst and dPc4 carry no meaning, so they are left alone.
        valid_q <= 1'b0;
      end else if (bus.Stall) begin
        // Hold IF/ID for the load-use hazard.
        valid_q <= valid_q;
      end else if (bus.Irdy) begin
        inst_q  <= bus.Idata;
        pc4_q   <= pc_plus4;
        valid_q <= 1'b1;
        cnt_q   <= cnt_q + 32'd1;
      end else begin
        // Memory wait: insert a bubble and keep dPc4.
        inst_q  <= 32'd0;
        valid_q <= 1'b0;
      end
    end
  end

  // deliver is kept as a named term; it matches the Fcnt increment condition.
  logic unused_deliver;
  assign unused_deliver = deliver;

  assign bus.Iaddr  = pc_q;
  assign bus.dInst  = inst_q;
  assign bus.dPc4   = pc4_q;
  assign bus.dValid = valid_q;
  assign bus.Fcnt   = cnt_q;

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch -- directed and random stimulus for pc_fetch. Expected IF/ID
// contents are queued when a deliverable fetch is driven. They are popped once
// the edge has loaded IF/ID.
module tb_pc_fetch;
  logic clk = 1'b0;
  logic rst;

  pc_fetch_if bus();

  pc_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] exp_q[$];
  logic [63:0] e;
  logic [31:0] m_pc, m_inst, m_pc4, m_cnt;
  logic        m_valid;
  logic        deliv;

  task automatic model_reset();
    m_pc    = 32'd0;
    m_inst  = 32'd0;
    m_pc4   = 32'd0;
    m_cnt   = 32'd0;
    m_valid = 1'b0;
    deliv   = 1'b0;
    exp_q.delete();
  endtask

  // Apply one cycle of inputs, update the reference model, then step to #1
  // after the rising edge.
  task automatic drive(input logic [1:0] pcsrc, input logic condep,
                       input logic [31:0] bt, input logic stall,
                       input logic [31:0] idata, input logic irdy);
    logic [31:0] jt;
    logic [31:0] nxt;
    bus.Pcsrc   = pcsrc;
    bus.Condep  = condep;
    bus.Btarget = bt;
    bus.Stall   = stall;
    bus.Idata   = idata;
    bus.Irdy    = irdy;
    jt    = {m_pc4[31:28], m_inst[25:0], 2'b00};
    deliv = condep && !stall && irdy;
    if (deliv) exp_q.push_back({idata, m_pc + 32'd4});
    if (pcsrc == 2'b10)                nxt = bt;
    else if (pcsrc == 2'b11 && !stall) nxt = jt;
    else if (stall || !irdy)           nxt = m_pc;
    else                               nxt = m_pc + 32'd4;
    if (!condep) begin
      m_valid = 1'b0;
    end else if (!stall) begin
      if (irdy) begin
        m_inst  = idata;
        m_pc4   = m_pc + 32'd4;
        m_valid = 1'b1;
        m_cnt   = m_cnt + 32'd1;
      end else begin
        m_valid = 1'b0;
        m_inst  = 32'd0;
      end
    end
    m_pc = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic seq(input logic [31:0] idata);
    drive(2'b00, 1'b1, 32'd0, 1'b0, idata, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.Pcsrc = 2'b00; bus.Condep = 1'b1; bus.Btarget = 32'd0;
    bus.Stall = 1'b0;  bus.Idata = 32'd0; bus.Irdy = 1'b1;
    model_reset();
    #12;
    n_checks++; if (bus.Iaddr !== 32'd0) $display("FAIL rst_iaddr got %h exp 00000000", bus.Iaddr); else n_pass++;
    n_checks++; if (bus.dInst !== 32'd0) $display("FAIL rst_dinst got %h exp 00000000", bus.dInst); else n_pass++;
    n_checks++; if (bus.dPc4 !== 32'd0) $display("FAIL rst_dpc4 got %h exp 00000000", bus.dPc4); else n_pass++;
    n_checks++; if (bus.dValid !== 1'b0) $display("FAIL rst_dvalid got %b exp 0", bus.dValid); else n_pass++;
    n_checks++; if (bus.Fcnt !== 32'd0) $display("FAIL rst_fcnt got %h exp 00000000", bus.Fcnt); else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr [3];
    exp_addr[0] = 32'h4; exp_addr[1] = 32'h8; exp_addr[2] = 32'hC;
    for (int i = 0; i < 3; i++) begin
      seq($urandom);
      n_checks++; if (bus.Iaddr !== exp_addr[i]) $display("FAIL seq_iaddr%0d got %h exp %h", i, bus.Iaddr, exp_addr[i]); else n_pass++;
      n_checks++; if (bus.dValid !== 1'b1) $display("FAIL seq_dvalid%0d got %b exp 1", i, bus.dValid); else n_pass++;
      n_checks++;
      if (exp_q.size() == 0) $display("FAIL seq_sb%0d got empty queue exp entry", i);
      else begin
        e = exp_q.pop_front();
        if ({bus.dInst, bus.dPc4} !== e) $display("FAIL seq_sb%0d got %h exp %h", i, {bus.dInst, bus.dPc4}, e); else n_pass++;
      end
    end
    n_checks++; if (bus.Fcnt !== 32'd3) $display("FAIL seq_fcnt got %h exp 00000003", bus.Fcnt); else n_pass++;
    n_checks++; if (bus.dPc4 !== 32'hC) $display("FAIL seq_dpc4 got %h exp 0000000c", bus.dPc4); else n_pass++;
  endtask

  task automatic test_branch();
    drive(2'b10, 1'b0, 32'h100, 1'b0, $urandom, 1'b1);
    drive(2'b10, 1'b0, 32'h200, 1'b0, $urandom, 1'b1);
    n_checks++; if (bus.Iaddr !== 32'h200) $display("FAIL br_iaddr got %h exp 00000200", bus.Iaddr); else n_pass++;
    n_checks++; if (bus.dValid !== 1'b0) $display("FAIL br_squash got %b exp 0", bus.dValid); else n_pass++;
    seq($urandom);
    n_checks++; if (bus.dPc4 !== 32'h204) $display("FAIL br_dpc4 got %h exp 00000204", bus.dPc4); else n_pass++;
    n_checks++; if (bus.dValid !== 1'b1) $display("FAIL br_dvalid got %b exp 1", bus.dValid); else n_pass++;
    n_checks++;
    if (exp_q.size() == 0) $display("FAIL br_sb got empty queue exp entry");
    else begin
      e = exp_q.pop_front();
      if ({bus.dInst, bus.dPc4} !== e) $display("FAIL br_sb got %h exp %h", {bus.dInst, bus.dPc4}, e); else n_pass++;
    end
  endtask

  task automatic test_jump();
    logic [31:0] ds;
    ds = $urandom;
    drive(2'b10, 1'b0, 32'h1000000C, 1'b0, $urandom, 1'b1);
    seq(32'h08000040);
    void'(exp_q.pop_front());
    n_checks++; if (bus.dInst !== 32'h08000040 || bus.dPc4 !== 32'h10000010)
      $display("FAIL jmp_setup got %h/%h exp 08000040/10000010", bus.dInst, bus.dPc4); else n_pass++;
    drive(2'b11, 1'b1, 32'd0, 1'b0, ds, 1'b1);
    n_checks++; if (bus.Iaddr !== 32'h10000100) $display("FAIL jmp_iaddr got %h exp 10000100", bus.Iaddr); else n_pass++;
    n_checks++; if (bus.dValid !== 1'b1 || bus.dInst !== ds || bus.dPc4 !== 32'h10000014)
      $display("FAIL jmp_delay_slot got %b/%h/%h exp 1/%h/10000014", bus.dValid, bus.dInst, bus.dPc4, ds); else n_pass++;
    void'(exp_q.pop_front());
  endtask

  task automatic test_stall_jump();
    logic [31:0] cnt_before;
    drive(2'b10, 1'b0, 32'h1000000C, 1'b0, $urandom, 1'b1);
    seq(32'h08000040);
    void'(exp_q.pop_front());
    cnt_before = m_cnt;
    for (int i = 0; i < 2; i++) begin
      drive(2'b11, 1'b1, 32'd0, 1'b1, $urandom, 1'b1);
      n_checks++; if (bus.Iaddr !== 32'h10000010) $display("FAIL stall_iaddr%0d got %h exp 10000010", i, bus.Iaddr); else n_pass++;
      n_checks++; if (bus.dInst !== 32'h08000040 || bus.dPc4 !== 32'h10000010 || bus.dValid !== 1'b1)
        $display("FAIL stall_ifid%0d got %h/%h/%b exp 08000040/10000010/1", i, bus.dInst, bus.dPc4, bus.dValid); else n_pass++;
      n_checks++; if (bus.Fcnt !== cnt_before) $display("FAIL stall_fcnt%0d got %h exp %h", i, bus.Fcnt, cnt_before); else n_pass++;
    end
    drive(2'b11, 1'b1, 32'd0, 1'b0, $urandom, 1'b1);
    n_checks++; if (bus.Iaddr !== 32'h10000100) $display("FAIL stall_jump_taken got %h exp 10000100", bus.Iaddr); else n_pass++;
    void'(exp_q.pop_front());
  endtask

  task automatic test_irdy_wait();
    drive(2'b10, 1'b1, 32'h300, 1'b0, $urandom, 1'b0);
    n_checks++; if (bus.Iaddr !== 32'h300) $display("FAIL wait_iaddr1 got %h exp 00000300", bus.Iaddr); else n_pass++;
    n_checks++; if (bus.dValid !== 1'b0 || bus.dInst !== 32'd0)
      $display("FAIL wait_bubble1 got %b/%h exp 0/00000000", bus.dValid, bus.dInst); else n_pass++;
    drive(2'b00, 1'b1, 32'd0, 1'b0, $urandom, 1'b0);
    n_checks++; if (bus.Iaddr !== 32'h300) $display("FAIL wait_iaddr2 got %h exp 00000300", bus.Iaddr); else n_pass++;
    n_checks++; if (bus.dValid !== 1'b0) $display("FAIL wait_bubble2 got %b exp 0", bus.dValid); else n_pass++;
    seq($urandom);
    n_checks++; if (bus.dPc4 !== 32'h304 || bus.dValid !== 1'b1)
      $display("FAIL wait_resume got %h/%b exp 00000304/1", bus.dPc4, bus.dValid); else n_pass++;
    n_checks++;
    if (exp_q.size() == 0) $display("FAIL wait_sb got empty queue exp entry");
    else begin
      e = exp_q.pop_front();
      if ({bus.dInst, bus.dPc4} !== e) $display("FAIL wait_sb got %h exp %h", {bus.dInst, bus.dPc4}, e); else n_pass++;
    end
  endtask

  task automatic test_wrap();
    drive(2'b10, 1'b0, 32'hFFFFFFFC, 1'b0, $urandom, 1'b1);
    seq($urandom);
    n_checks++; if (bus.Iaddr !== 32'd0) $display("FAIL wrap_iaddr got %h exp 00000000", bus.Iaddr); else n_pass++;
    n_checks++; if (bus.dPc4 !== 32'd0) $display("FAIL wrap_dpc4 got %h exp 00000000", bus.dPc4); else n_pass++;
    void'(exp_q.pop_front());
  endtask

  task automatic test_reset_mid();
    drive(2'b10, 1'b1, 32'h500, 1'b1, $urandom, 1'b1);
    // A redirect and a stall are pending when reset hits between edges.
    bus.Pcsrc = 2'b10; bus.Btarget = 32'h700; bus.Stall = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.Iaddr !== 32'd0) $display("FAIL mid_rst_iaddr got %h exp 00000000", bus.Iaddr); else n_pass++;
    n_checks++; if (bus.dInst !== 32'd0 || bus.dPc4 !== 32'd0 || bus.dValid !== 1'b0)
      $display("FAIL mid_rst_ifid got %h/%h/%b exp 0/0/0", bus.dInst, bus.dPc4, bus.dValid); else n_pass++;
    n_checks++; if (bus.Fcnt !== 32'd0) $display("FAIL mid_rst_fcnt got %h exp 00000000", bus.Fcnt); else n_pass++;
    @(posedge clk);
    #1;
    bus.Pcsrc = 2'b00; bus.Stall = 1'b0; bus.Irdy = 1'b1; bus.Condep = 1'b1;
    rst = 1'b0;
    model_reset();
    seq($urandom);
    n_checks++; if (bus.Iaddr !== 32'h4 || bus.dPc4 !== 32'h4 || bus.dValid !== 1'b1 || bus.Fcnt !== 32'd1)
      $display("FAIL mid_rst_first got %h/%h/%b/%h exp 4/4/1/1", bus.Iaddr, bus.dPc4, bus.dValid, bus.Fcnt); else n_pass++;
    void'(exp_q.pop_front());
  endtask

  task automatic test_random();
    logic [1:0] pcsrc;
    for (int i = 0; i < 80; i++) begin
      pcsrc = 2'($urandom_range(0, 3));
      if (pcsrc == 2'b11 && !m_valid) pcsrc = 2'b00;
      drive(pcsrc, $urandom_range(0, 4) != 0, $urandom & 32'hFFFFFFFC,
            $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 3) != 0);
      n_checks++; if (bus.Iaddr !== m_pc) $display("FAIL rnd_iaddr%0d got %h exp %h", i, bus.Iaddr, m_pc); else n_pass++;
      n_checks++; if (bus.dValid !== m_valid) $display("FAIL rnd_dvalid%0d got %b exp %b", i, bus.dValid, m_valid); else n_pass++;
      n_checks++; if (bus.Fcnt !== m_cnt) $display("FAIL rnd_fcnt%0d got %h exp %h", i, bus.Fcnt, m_cnt); else n_pass++;
      if (deliv) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL rnd_sb%0d got empty queue exp entry", i);
        else begin
          e = exp_q.pop_front();
          if ({bus.dInst, bus.dPc4} !== e) $display("FAIL rnd_sb%0d got %h exp %h", i, {bus.dInst, bus.dPc4}, e); else n_pass++;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_stall_jump();
    test_irdy_wait();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
